// File: rtl/display_driver_pkg.sv
// Shared definitions for the LED panel row scanner.
//   state_t       : scanner FSM states.
//   CH_R1..CH_B2  : channel slot of each colour in mem_rdata (slot 5 = MSBs)
//                   and, equally, the bit of panel_rgb that carries it.
package display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  localparam int NUM_CHANNELS = 6;
  localparam int CH_R1 = 5;
  localparam int CH_G1 = 4;
  localparam int CH_B1 = 3;
  localparam int CH_R2 = 2;
  localparam int CH_G2 = 1;
  localparam int CH_B2 = 0;

endpackage

// File: rtl/display_driver_column_shifter.sv
// Shifts one row of one bit plane into the panel.
//   start        : one-cycle pulse; issues the read of column 0 of 'row'.
//   row          : row being shifted (held stable by the caller).
//   pulse_select : bit plane, captured in the first shift cycle into 'plane'.
//   mem_addr     : {row, column} read address to the synchronous RAM.
//   mem_rdata    : pixel data, valid the cycle after mem_addr.
//   panel_rgb    : plane bits of R1,G1,B1,R2,G2,B2 for the current column.
//   panel_clk    : one high cycle per column, preceded by a low cycle.
//   plane        : captured bit plane for the whole shift.
//   done         : one-cycle pulse in the cycle of the last panel_clk high.
module display_driver_column_shifter
  import display_driver_pkg::*;
#(
  parameter int columns  = 64,
  parameter int rows     = 16,
  parameter int bitwidth = 8,
  localparam int CW = $clog2(columns),
  localparam int RW = $clog2(rows),
  localparam int PW = $clog2(bitwidth)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RW-1:0]            row,
  input  logic [PW-1:0]            pulse_select,
  input  logic [6*bitwidth-1:0]    mem_rdata,
  output logic [RW+CW-1:0]         mem_addr,
  output logic [NUM_CHANNELS-1:0]  panel_rgb,
  output logic                     panel_clk,
  output logic [PW-1:0]            plane,
  output logic                     done
);

  logic          busy;
  logic          prime;  // waiting out the RAM latency of column 0
  logic          raise;  // next step raises panel_clk (else: load data)
  logic [CW-1:0] col;

  function automatic logic [NUM_CHANNELS-1:0] plane_bits(
    input logic [6*bitwidth-1:0] d,
    input logic [PW-1:0]         p
  );
    int pi;
    pi = int'(p);
    plane_bits = '0;
    plane_bits[CH_R1] = d[CH_R1*bitwidth + pi];
    plane_bits[CH_G1] = d[CH_G1*bitwidth + pi];
    plane_bits[CH_B1] = d[CH_B1*bitwidth + pi];
    plane_bits[CH_R2] = d[CH_R2*bitwidth + pi];
    plane_bits[CH_G2] = d[CH_G2*bitwidth + pi];
    plane_bits[CH_B2] = d[CH_B2*bitwidth + pi];
  endfunction

  // Each column takes two cycles: a low cycle where panel_rgb is loaded from
  // the RAM and the next address is issued, then a high cycle. The address
  // for column k+1 is therefore out one full cycle before its data is used.
  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values; blocking ones here would create ordering-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      prime     <= 1'b0;
      raise     <= 1'b0;
      col       <= '0;
      mem_addr  <= '0;
      panel_rgb <= '0;
      panel_clk <= 1'b0;
      plane     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy      <= 1'b1;
        prime     <= 1'b1;
        raise     <= 1'b0;
        col       <= '0;
        mem_addr  <= {row, CW'(0)};
        panel_clk <= 1'b0;
      end else if (busy) begin
        if (prime) begin
          // Capturing here rather than on the start edge lets the pulse
          // generator advance its select on the same edge as complete.
          prime <= 1'b0;
          plane <= pulse_select;
        end else if (!raise) begin
          panel_rgb           <= plane_bits(mem_rdata, plane);
          panel_clk           <= 1'b0;
          mem_addr[CW-1:0]    <= col + CW'(1);
          raise               <= 1'b1;
        end else begin
          panel_clk <= 1'b1;
          raise     <= 1'b0;
          if (col == CW'(columns - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            col <= col + CW'(1);
          end
        end
      end else begin
        panel_clk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/display_driver_row_scanner.sv
// HUB75-style row scanner: shifts one bit plane of a row, latches it, then
// lights it for one pulse-generator pulse (binary-coded modulation).
//   clk, rst       : clock, asynchronous active-high reset.
//   enable         : run scanning; sampled only in IDLE and at DISPLAY end.
//   mem_addr       : {row, column} pixel read address (sync RAM, 1-cycle).
//   mem_rdata      : {R1,G1,B1,R2,G2,B2}, bitwidth bits each.
//   pulse_go       : request to the pulse generator (high through DISPLAY).
//   pulse_complete : end of pulse from the generator.
//   pulse_select   : bit plane the generator will time next.
//   panel_*        : panel data, shift clock, latch, output enable (active
//                    low) and row address.
//   frame_done     : one-cycle pulse when the row counter wraps to 0.
module display_driver_row_scanner
  import display_driver_pkg::*;
#(
  parameter int columns  = 64,
  parameter int rows     = 16,
  parameter int bitwidth = 8,
  localparam int CW = $clog2(columns),
  localparam int RW = $clog2(rows),
  localparam int PW = $clog2(bitwidth)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [RW+CW-1:0]        mem_addr,
  input  logic [6*bitwidth-1:0]   mem_rdata,
  output logic                    pulse_go,
  input  logic                    pulse_complete,
  input  logic [PW-1:0]           pulse_select,
  output logic [NUM_CHANNELS-1:0] panel_rgb,
  output logic                    panel_clk,
  output logic                    panel_lat,
  output logic                    panel_oe,
  output logic [RW-1:0]           panel_addr,
  output logic                    frame_done
);

  state_t        state, state_next;
  logic          start;
  logic          shift_done;
  logic [PW-1:0] plane;
  logic [RW-1:0] row;
  logic          last_plane;

  display_driver_column_shifter #(
    .columns  (columns),
    .rows     (rows),
    .bitwidth (bitwidth)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .row          (row),
    .pulse_select (pulse_select),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .panel_rgb    (panel_rgb),
    .panel_clk    (panel_clk),
    .plane        (plane),
    .done         (shift_done)
  );

  assign last_plane = (plane == PW'(bitwidth - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_SHIFT;
          start      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (shift_done) state_next = ST_LATCH;
      end
      ST_LATCH: begin
        state_next = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        if (pulse_complete) begin
          state_next = enable ? ST_SHIFT : ST_IDLE;
          start      = enable;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe; pulse_go/panel_oe therefore drop on the same edge
  // that samples pulse_complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_go   <= 1'b0;
      panel_oe   <= 1'b1;
      panel_lat  <= 1'b0;
      panel_addr <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      pulse_go   <= (state_next == ST_DISPLAY);
      panel_oe   <= (state_next != ST_DISPLAY);
      panel_lat  <= (state_next == ST_LATCH);
      frame_done <= 1'b0;
      if (state_next == ST_LATCH) panel_addr <= row;
      if (state == ST_DISPLAY && pulse_complete && last_plane) begin
        row        <= row + RW'(1);
        frame_done <= (row == RW'(rows - 1));
      end
    end
  end

endmodule

// File: tb/tb_display_driver_row_scanner.sv
module tb_display_driver_row_scanner;

  localparam int COLUMNS  = 4;
  localparam int ROWS     = 2;
  localparam int BITWIDTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  mem_addr;
  logic [47:0] mem_rdata;
  logic        pulse_go;
  logic        pulse_complete;
  logic [2:0]  pulse_select;
  logic [5:0]  panel_rgb;
  logic        panel_clk;
  logic        panel_lat;
  logic        panel_oe;
  logic [0:0]  panel_addr;
  logic        frame_done;

  always #5 clk = ~clk;

  display_driver_row_scanner #(
    .columns  (COLUMNS),
    .rows     (ROWS),
    .bitwidth (BITWIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .pulse_go       (pulse_go),
    .pulse_complete (pulse_complete),
    .pulse_select   (pulse_select),
    .panel_rgb      (panel_rgb),
    .panel_clk      (panel_clk),
    .panel_lat      (panel_lat),
    .panel_oe       (panel_oe),
    .panel_addr     (panel_addr),
    .frame_done     (frame_done)
  );

  // ---------------- RAM model: every channel of pixel (r,c) = 8'h01 << c
  function automatic logic [47:0] pixel(input logic [1:0] c);
    logic [7:0] ch;
    ch = 8'h01 << c;
    return {6{ch}};
  endfunction

  always @(posedge clk) mem_rdata <= pixel(mem_addr[1:0]);

  // ---------------- pulse generator model: plane p lasts 256 >> p cycles
  logic [8:0] pg_cnt;
  logic [2:0] pg_sel;
  logic       stray;

  function automatic int width_of(input int p);
    return 256 >> p;
  endfunction

  assign pulse_complete = (pulse_go && int'(pg_cnt) == width_of(int'(pg_sel)) - 1) || stray;
  assign pulse_select   = pg_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_cnt <= '0;
      pg_sel <= '0;
    end else if (pulse_go) begin
      if (pulse_complete) begin
        pg_cnt <= '0;
        pg_sel <= pg_sel + 3'd1;
      end else begin
        pg_cnt <= pg_cnt + 9'd1;
      end
    end else begin
      pg_cnt <= '0;
    end
  end

  // ---------------- checking
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard
  logic [5:0] exp_rgb[$];
  int         exp_addr[$];
  int         exp_w[$];

  task automatic push_plane(input int r, input int p);
    for (int k = 0; k < COLUMNS; k++) exp_rgb.push_back((k == p) ? 6'h3F : 6'h00);
    exp_addr.push_back(r);
    exp_w.push_back(width_of(p));
  endtask

  logic       mon_on = 1'b1;
  logic       prev_clk = 1'b0, prev_lat = 1'b0, prev_oe = 1'b1, prev_fd = 1'b0;
  logic [5:0] prev_rgb = '0;
  int         oe_run = 0;
  int         displays_done = 0;
  int         fd_count = 0;

  always @(negedge clk) begin
    if (!rst && mon_on) begin
      if (panel_clk && !prev_clk) begin
        if (exp_rgb.size() == 0) check("clk_extra", 32'(panel_clk), 32'(0));
        else                     check("rgb", 32'(panel_rgb), 32'(exp_rgb.pop_front()));
      end
      if (panel_clk) check("rgb_stable", 32'(panel_rgb), 32'(prev_rgb));
      if (panel_lat) begin
        check("lat_single", 32'(prev_lat), 32'(0));
        check("lat_clk", 32'(panel_clk), 32'(0));
        check("lat_oe", 32'(panel_oe), 32'(1));
        if (exp_addr.size() == 0) check("lat_extra", 32'(panel_lat), 32'(0));
        else                      check("lat_addr", 32'(panel_addr), 32'(exp_addr.pop_front()));
      end
      if (!panel_oe) begin
        oe_run++;
        check("go_during_oe", 32'(pulse_go), 32'(1));
      end else if (!prev_oe) begin
        check("go_after_complete", 32'(pulse_go), 32'(0));
        if (exp_w.size() == 0) check("oe_extra", 32'(oe_run), 32'(0));
        else                   check("oe_width", 32'(oe_run), 32'(exp_w.pop_front()));
        displays_done++;
        oe_run = 0;
      end
      if (frame_done) begin
        check("fd_single", 32'(prev_fd), 32'(0));
        check("fd_position", 32'(displays_done), 32'(16));
        fd_count++;
      end
    end else begin
      oe_run = 0;
    end
    prev_clk = panel_clk;
    prev_lat = panel_lat;
    prev_oe  = panel_oe;
    prev_fd  = frame_done;
    prev_rgb = panel_rgb;
  end

  task automatic wait_displays(input int n, input int budget);
    int k;
    k = 0;
    while (displays_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("displays_reached", 32'(displays_done), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'(0));
    check({tag, "_pulse_go"},   32'(pulse_go),   32'(0));
    check({tag, "_panel_rgb"},  32'(panel_rgb),  32'(0));
    check({tag, "_panel_clk"},  32'(panel_clk),  32'(0));
    check({tag, "_panel_lat"},  32'(panel_lat),  32'(0));
    check({tag, "_panel_oe"},   32'(panel_oe),   32'(1));
    check({tag, "_panel_addr"}, 32'(panel_addr), 32'(0));
    check({tag, "_frame_done"}, 32'(frame_done), 32'(0));
  endtask

  // ---------------- stimulus
  initial begin
    int n;
    int base;
    rst    = 1'b1;
    enable = 1'b0;
    stray  = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full frame (row 0 planes 0..7, row 1 planes 0..7) plus two planes of
    // the next frame so the row address is seen returning to 0.
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < BITWIDTH; p++) push_plane(r, p);
    push_plane(0, 0);
    push_plane(0, 1);

    enable = 1'b1;
    n = 0;
    while (!panel_clk && n < 10) begin
      @(negedge clk);
      n++;
    end
    // n counts the enable-sampling edge too, so n-1 cycles follow it.
    check("first_edge_latency", 32'(n >= 1 && n - 1 <= 3), 32'(1));

    wait_displays(16, 5000);
    check("frame_done_count", 32'(fd_count), 32'(1));
    check("addr_end_of_frame", 32'(panel_addr), 32'(1));

    // Drop enable part-way through the plane-1 pulse of the new frame.
    wait_displays(17, 1000);
    n = 0;
    while (panel_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("display_started", 32'(panel_oe), 32'(0));
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_displays(18, 1000);
    check("frame_done_once", 32'(fd_count), 32'(1));

    // A stray complete in IDLE must not wake anything up.
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_oe", 32'(panel_oe), 32'(1));
      check("idle_go", 32'(pulse_go), 32'(0));
      check("idle_clk", 32'(panel_clk), 32'(0));
    end
    check("rgb_left", 32'(exp_rgb.size()), 32'(0));
    check("addr_left", 32'(exp_addr.size()), 32'(0));
    check("width_left", 32'(exp_w.size()), 32'(0));

    // Asynchronous reset in the middle of a shift, between clock edges.
    mon_on = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!panel_clk && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("shift_reached", 32'(panel_clk), 32'(1));
    #2 rst = 1'b1;
    #1 check_reset_outputs("async");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;
    base = displays_done;
    push_plane(0, 0);
    enable = 1'b1;
    wait_displays(base + 1, 1000);
    check("restart_rgb_left", 32'(exp_rgb.size()), 32'(0));
    check("restart_addr_left", 32'(exp_addr.size()), 32'(0));
    check("restart_row", 32'(panel_addr), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
